// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Program counter and fetch stage for the 16-bit CPU. Holds the PC, drives
// the instruction-memory address, captures fetched instructions into the
// IF/ID register, resolves conditional/register branches from {N,V,Z}, and
// runs a halt drain so hlt asserts only after older instructions retire.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hold PC, IF/ID, state and drain counter
//   br_valid          branch/jump resolved this cycle
//   br_is_reg         1: target = br_reg_target, 0: PC-relative
//   br_cond           condition code
//   br_flags          {N,V,Z}
//   br_imm            signed branch offset
//   br_pc_inc         PC+PC_STEP of the branch instruction
//   br_reg_target     register branch target
//   imem_instr        instruction at imem_addr (combinational read)
//   imem_addr         current PC
//   if_id_instr       registered instruction
//   if_id_pc_inc      registered PC+PC_STEP
//   if_id_valid       IF/ID holds a live instruction
//   redirect          taken branch this cycle (combinational)
//   hlt               processor halted (registered)
module fetch_pc_unit #(
    parameter int                ADDR_W       = 16,
    parameter int                INSTR_W      = 16,
    parameter int                IMM_W        = 9,
    parameter int                PC_STEP      = 2,
    parameter int                IMM_SHIFT    = 1,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter logic [3:0]        HLT_OPCODE   = 4'hF,
    parameter int                DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               br_valid,
    input  logic               br_is_reg,
    input  logic [2:0]         br_cond,
    input  logic [2:0]         br_flags,
    input  logic [IMM_W-1:0]   br_imm,
    input  logic [ADDR_W-1:0]  br_pc_inc,
    input  logic [ADDR_W-1:0]  br_reg_target,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_inc,
    output logic               if_id_valid,
    output logic               redirect,
    output logic               hlt
);

    localparam int                CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         pc_next;
    logic [ADDR_W-1:0]         target;
    logic [ADDR_W+IMM_W-1:0]   imm_sext;
    logic                      cond_true;
    logic                      n_flag;
    logic                      v_flag;
    logic                      z_flag;
    logic                      is_hlt;

    assign n_flag = br_flags[2];
    assign v_flag = br_flags[1];
    assign z_flag = br_flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = !z_flag;
            3'b001:  cond_true = z_flag;
            3'b010:  cond_true = !z_flag && !n_flag;
            3'b011:  cond_true = n_flag;
            3'b100:  cond_true = z_flag || (!z_flag && !n_flag);
            3'b101:  cond_true = n_flag || z_flag;
            3'b110:  cond_true = v_flag;
            default: cond_true = 1'b1;
        endcase
    end

    // Sign-extend to a width that survives the shift, then truncate: the sum
    // wraps modulo 2^ADDR_W.
    assign imm_sext = {{ADDR_W{br_imm[IMM_W-1]}}, br_imm};
    assign target   = br_is_reg ? br_reg_target
                                : br_pc_inc + ADDR_W'(imm_sext << IMM_SHIFT);

    assign redirect  = br_valid && cond_true && (state != HALTED);
    assign pc_next   = pc + STEP;
    assign is_hlt    = (imem_instr[INSTR_W-1 -: 4] == HLT_OPCODE);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            if_id_instr  <= '0;
            if_id_pc_inc <= '0;
            if_id_valid  <= 1'b0;
            hlt          <= 1'b0;
            state        <= RUN;
            cnt          <= '0;
        end else if (state != HALTED) begin
            if (redirect) begin
                // A redirect in DRAIN means the HLT was on the wrong path.
                pc          <= target;
                if_id_valid <= 1'b0;
                state       <= RUN;
                cnt         <= '0;
            end else if (!stall) begin
                case (state)
                    RUN: begin
                        if_id_instr  <= imem_instr;
                        if_id_pc_inc <= pc_next;
                        if_id_valid  <= 1'b1;
                        if (is_hlt) begin
                            state <= DRAIN;
                            cnt   <= CNT_W'(DRAIN_CYCLES);
                        end else begin
                            pc <= pc_next;
                        end
                    end
                    DRAIN: begin
                        if_id_valid <= 1'b0;
                        cnt         <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= HALTED;
                            hlt   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
